// File: rtl/posit_pkg.sv
// rtl/posit_pkg.sv - shared constants and FSM state type for the posit encoder
package posit_pkg;

  localparam int POSIT_W = 32;
  localparam int ES      = 3;
  localparam int K_MAX   = 30;
  localparam int K_MIN   = -30;
  localparam logic [31:0] MAXPOS = 32'h7FFFFFFF;
  localparam logic [31:0] MINPOS = 32'h00000001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BUILD,
    S_ROUND,
    S_PACK,
    S_DONE
  } state_t;

endpackage

// File: rtl/posit_regime_shift.sv
// rtl/posit_regime_shift.sv - combinational body builder: regime, exponent, fraction left-aligned
//
// Ports:
//   k        signed regime value (-32..31)
//   exp_bits exponent field
//   frac     fraction bits (hidden bit removed)
//   work     body left-aligned in WORK_W bits: regime, then exp_bits, then frac
module posit_regime_shift
  import posit_pkg::*;
#(
  parameter int WORK_W = 72
) (
  input  logic signed [5:0]        k,
  input  logic        [ES-1:0]     exp_bits,
  input  logic        [30:0]       frac,
  output logic        [WORK_W-1:0] work
);

  localparam int TAIL_W = ES + 31;

  logic [6:0]        neg_k;
  logic [6:0]        run_len;
  logic [WORK_W-1:0] regime;
  logic [WORK_W-1:0] tail;

  always_comb begin
    // 7-bit negation so that k = -32 yields +32 without wrapping
    neg_k = 7'd0 - {k[5], k};
    tail  = {exp_bits, frac, {(WORK_W-TAIL_W){1'b0}}};
    if (!k[5]) begin
      // k+1 ones then a zero: inverting a right-shifted all-ones mask leaves the ones on top
      regime  = ~({WORK_W{1'b1}} >> ({1'b0, k} + 7'd1));
      run_len = {1'b0, k} + 7'd2;
    end else begin
      // -k zeros then a one
      regime  = {1'b1, {(WORK_W-1){1'b0}}} >> neg_k;
      run_len = neg_k + 7'd1;
    end
    work = regime | (tail >> run_len);
  end

endmodule

// File: rtl/posit_encode.sv
// rtl/posit_encode.sv - final posit packing stage: regime placement, RNE rounding, saturation, sign
//
// Ports:
//   clk, rst_n    clock and asynchronous active-low reset
//   start         launch pulse, sampled only in IDLE
//   sign_in       result sign (1 = negative)
//   k_in          signed regime value
//   exp_in        exponent field
//   mantissa_in   bit 31 hidden bit, bits [30:0] fraction
//   posit_out     encoded posit, held until the next result
//   busy          high whenever the FSM is not idle
//   done          one-cycle pulse when posit_out takes a new value
module posit_encode
  import posit_pkg::*;
#(
  parameter int WORK_W = 72
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                sign_in,
  input  logic signed [5:0]   k_in,
  input  logic        [2:0]   exp_in,
  input  logic        [31:0]  mantissa_in,
  output logic        [31:0]  posit_out,
  output logic                busy,
  output logic                done
);

  localparam logic signed [5:0] K_HI = K_MAX[5:0];
  localparam logic signed [5:0] K_LO = K_MIN[5:0];

  state_t state, state_nxt;

  logic                        sign_r;
  logic signed [5:0]           k_r;
  logic        [2:0]           exp_r;
  logic        [31:0]          mant_r;
  logic        [WORK_W-1:0]    work_r;
  logic                        special_r;
  logic        [POSIT_W-2:0]   special_body_r;
  logic        [POSIT_W-2:0]   body_r;
  logic        [31:0]          pack_r;

  logic        [WORK_W-1:0]    work_c;
  logic        [POSIT_W-2:0]   keep;
  logic                        guard;
  logic                        sticky;
  logic                        inc;
  logic        [POSIT_W-1:0]   sum;

  posit_regime_shift #(.WORK_W(WORK_W)) u_shift (
    .k        (k_r),
    .exp_bits (exp_r),
    .frac     (mant_r[30:0]),
    .work     (work_c)
  );

  always_comb begin
    keep   = work_r[WORK_W-1 -: POSIT_W-1];
    guard  = work_r[WORK_W-POSIT_W];
    sticky = |work_r[WORK_W-POSIT_W-1:0];
    inc    = guard & (keep[0] | sticky);
    sum    = {1'b0, keep} + {{(POSIT_W-1){1'b0}}, inc};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_BUILD;
      S_BUILD: state_nxt = S_ROUND;
      S_ROUND: state_nxt = S_PACK;
      S_PACK:  state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_r         <= 1'b0;
      k_r            <= '0;
      exp_r          <= '0;
      mant_r         <= '0;
      work_r         <= '0;
      special_r      <= 1'b0;
      special_body_r <= '0;
      body_r         <= '0;
      pack_r         <= '0;
      posit_out      <= '0;
      done           <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            sign_r <= sign_in;
            k_r    <= k_in;
            exp_r  <= exp_in;
            mant_r <= mantissa_in;
          end
        end
        S_BUILD: begin
          work_r <= work_c;
          if (!mant_r[31]) begin
            special_r      <= 1'b1;
            special_body_r <= '0;
          end else if (k_r > K_HI) begin
            special_r      <= 1'b1;
            special_body_r <= MAXPOS[POSIT_W-2:0];
          end else if (k_r < K_LO) begin
            special_r      <= 1'b1;
            special_body_r <= MINPOS[POSIT_W-2:0];
          end else begin
            special_r      <= 1'b0;
            special_body_r <= '0;
          end
        end
        S_ROUND: begin
          if (special_r) begin
            body_r <= special_body_r;
          end else if (sum[POSIT_W-1]) begin
            body_r <= MAXPOS[POSIT_W-2:0];
          end else if (sum[POSIT_W-2:0] == '0) begin
            // reaching here means the mantissa was nonzero, so keep minpos
            body_r <= MINPOS[POSIT_W-2:0];
          end else begin
            body_r <= sum[POSIT_W-2:0];
          end
        end
        S_PACK: begin
          // body never exceeds 0x7FFFFFFF, so negation cannot reach NaR; a zero body stays zero
          pack_r <= sign_r ? (32'd0 - {1'b0, body_r}) : {1'b0, body_r};
        end
        S_DONE: begin
          posit_out <= pack_r;
          done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != S_IDLE);

endmodule
